uart_8250: RTL and testbench



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_8250_if.sv | 12 +
 rtl/uart_rx.sv | 105 ++++++++++
 rtl/uart_8250.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_uart_8250.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8250-style COM port: register offsets,
// IIR codes, serial FSM states and the interrupt priority encoder.
package uart_pkg;

  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_IIR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_MCR = 3'd4;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_MSR = 3'd6;
  localparam logic [2:0] REG_SCR = 3'd7;

  localparam logic [7:0] IIR_LS   = 8'h06;
  localparam logic [7:0] IIR_RX   = 8'h04;
  localparam logic [7:0] IIR_THRE = 8'h02;
  localparam logic [7:0] IIR_NONE = 8'h01;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Highest-priority pending cause wins.
  function automatic logic [7:0] iir_code(input logic ls, input logic rx, input logic thre);
    if (ls) begin
      return IIR_LS;
    end else if (rx) begin
      return IIR_RX;
    end else if (thre) begin
      return IIR_THRE;
    end else begin
      return IIR_NONE;
    end
  endfunction

endpackage

// File: rtl/uart_8250_if.sv
// CPU I/O bus view of the COM port: address/data/strobes in, select/read data out.
interface uart_8250_if;
  logic [19:0] iAddr;
  logic [7:0]  iData;
  logic        iWr;
  logic        iRd;
  logic        oSel;
  logic [7:0]  oData;

  modport master (output iAddr, iData, iWr, iRd, input oSel, oData);
  modport slave  (input iAddr, iData, iWr, iRd, output oSel, oData);
endinterface

// File: rtl/uart_rx.sv
// 16x oversampled 8N1 receiver: synchronizer, start validation, mid-bit
// sampling; emits a one-cycle byte_valid with data and stop-bit status.
module uart_rx
  import uart_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst,
  input  logic       tick,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       brk
);
  rx_state_t  state_r, state_s;
  logic [1:0] sync_r;
  logic [3:0] cnt_r, cnt_s;
  logic [2:0] bit_r, bit_s;
  logic [7:0] shift_r, shift_s;
  logic       valid_r, valid_s, fe_r, fe_s, brk_r, brk_s;
  logic       rx_s;

  assign rx_s       = sync_r[1];
  assign byte_valid = valid_r;
  assign data       = shift_r;
  assign frame_err  = fe_r;
  assign brk        = brk_r;

  // Synchronizer and FSM state registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync_r  <= 2'b11;
      state_r <= RX_IDLE;
      cnt_r   <= 4'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      valid_r <= 1'b0;
      fe_r    <= 1'b0;
      brk_r   <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], rx};
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      valid_r <= valid_s;
      fe_r    <= fe_s;
      brk_r   <= brk_s;
    end
  end

  // Next-state: everything advances only on tick, so a zero divisor freezes the FSM
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    valid_s = 1'b0;
    fe_s    = fe_r;
    brk_s   = brk_r;
    if (tick) begin
      cnt_s = cnt_r + 4'd1;
      case (state_r)
        RX_IDLE: begin
          cnt_s = 4'd0;
          if (!rx_s) state_s = RX_START;
          else       state_s = RX_IDLE;
        end
        RX_START: begin
          if (cnt_r == 4'd7) begin
            cnt_s = 4'd0;
            bit_s = 3'd0;
            if (rx_s) state_s = RX_IDLE;
            else      state_s = RX_DATA;
          end else begin
            state_s = RX_START;
          end
        end
        RX_DATA: begin
          if (cnt_r == 4'd15) begin
            shift_s = {rx_s, shift_r[7:1]};
            bit_s   = bit_r + 3'd1;
            if (bit_r == 3'd7) state_s = RX_STOP;
            else               state_s = RX_DATA;
          end else begin
            state_s = RX_DATA;
          end
        end
        RX_STOP: begin
          if (cnt_r == 4'd15) begin
            valid_s = 1'b1;
            fe_s    = ~rx_s;
            brk_s   = ~rx_s & (shift_r == 8'h00);
            state_s = RX_IDLE;
          end else begin
            state_s = RX_STOP;
          end
        end
        default: state_s = RX_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end
endmodule

// File: rtl/uart_8250.sv
// COM1-compatible 8250 register subset, fixed 8N1, fractional baud reference.
// Define UART_RX_FIFO_EN to replace the single RBR with a 16-entry RX FIFO.
module uart_8250
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'h03F8,
  parameter int          ACC_INC = 18432,
  parameter int          ACC_MOD = 100000,
  parameter logic [15:0] RST_DIV = 16'd12
) (
  input  logic       iClk,
  input  logic       iRst,
  uart_8250_if.slave bus,
  input  logic       iRx,
  output logic       oTx,
  input  logic       iCts,
  input  logic       iDsr,
  output logic       oRts,
  output logic       oDtr,
  output logic       oIrq
);
  logic        hit_s, wr_s, rd_s, dlab_s, unused_s;
  logic [2:0]  off_s;
  logic        thr_wr_s, div_wr_s, ier_rise_s, iir_clr_s, rbr_rd_s, lsr_rd_s;
  logic [15:0] div_s, div_new_s, cnt_r;
  logic [16:0] acc_r, acc_sum_s;
  logic        ref_en_r, tick_r;
  logic [7:0]  dll_r, dlm_r, lcr_r, scr_r, thr_r, rdata_s, rbr_s, iir_s, lsr_s, msr_s;
  logic [3:0]  ier_r;
  logic [4:0]  mcr_r;
  logic        thr_full_r, thre_pend_r, oe_r, fe_r, bi_r, irq_r, tx_out_r, dr_s, ovr_s;
  logic [1:0]  cts_sync_r, dsr_sync_r;
  tx_state_t   tx_state_r, tx_state_s;
  logic [3:0]  tx_cnt_r, tx_cnt_s;
  logic [2:0]  tx_bit_r, tx_bit_s;
  logic [7:0]  tx_shift_r, tx_shift_s, rx_data_s;
  logic        tx_load_s, tx_line_s, rx_in_s, rx_valid_s, rx_fe_s, rx_brk_s;

  assign unused_s   = &{1'b0, bus.iAddr[19:16]};
  assign off_s      = bus.iAddr[2:0];
  assign hit_s      = (bus.iAddr[15:3] == BASE[15:3]);
  assign wr_s       = bus.iWr & hit_s;
  assign rd_s       = bus.iRd & hit_s;
  assign dlab_s     = lcr_r[7];
  assign thr_wr_s   = wr_s & (off_s == REG_RBR) & ~dlab_s;
  assign div_wr_s   = wr_s & ((off_s == REG_RBR) | (off_s == REG_IER)) & dlab_s;
  assign div_new_s  = (off_s == REG_RBR) ? {dlm_r, bus.iData} : {bus.iData, dll_r};
  assign ier_rise_s = wr_s & (off_s == REG_IER) & ~dlab_s & bus.iData[1] & ~ier_r[1];
  assign rbr_rd_s   = rd_s & (off_s == REG_RBR) & ~dlab_s;
  assign lsr_rd_s   = rd_s & (off_s == REG_LSR);
  assign iir_clr_s  = rd_s & (off_s == REG_IIR) & (iir_s[3:0] == IIR_THRE[3:0]);
  assign div_s      = {dlm_r, dll_r};
  assign acc_sum_s  = acc_r + 17'(ACC_INC);

`ifdef UART_RX_FIFO_EN
  localparam logic [7:0] IIR_FIFO_BITS = 8'hC0;
  logic [7:0] fifo_mem_r [16];
  logic [3:0] wp_r, rp_r;
  logic [4:0] fill_r;
  logic       push_s, pop_s;
  assign push_s = rx_valid_s & (fill_r != 5'd16);
  assign pop_s  = rbr_rd_s & (fill_r != 5'd0);
  assign ovr_s  = rx_valid_s & (fill_r == 5'd16);
  assign dr_s   = (fill_r != 5'd0);
  assign rbr_s  = fifo_mem_r[rp_r];

  // FIFO storage; only entries below fill_r are ever visible
  always_ff @(posedge iClk) begin
    if (push_s) fifo_mem_r[wp_r] <= rx_data_s;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wp_r   <= 4'd0;
      rp_r   <= 4'd0;
      fill_r <= 5'd0;
    end else begin
      if (push_s) wp_r <= wp_r + 4'd1;
      if (pop_s)  rp_r <= rp_r + 4'd1;
      fill_r <= fill_r + {4'd0, push_s} - {4'd0, pop_s};
    end
  end
`else
  localparam logic [7:0] IIR_FIFO_BITS = 8'h00;
  logic [7:0] rbr_r;
  logic       dr_r;
  assign ovr_s = rx_valid_s & dr_r & ~rbr_rd_s;
  assign dr_s  = dr_r;
  assign rbr_s = rbr_r;

  // Single receive buffer; a new byte always overwrites
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rbr_r <= 8'h00;
      dr_r  <= 1'b0;
    end else if (rx_valid_s) begin
      rbr_r <= rx_data_s;
      dr_r  <= 1'b1;
    end else if (rbr_rd_s) begin
      dr_r  <= 1'b0;
    end
  end
`endif

  assign iir_s = iir_code(ier_r[2] & (oe_r | fe_r | bi_r), ier_r[0] & dr_s,
                          ier_r[1] & thre_pend_r) | IIR_FIFO_BITS;
  assign lsr_s = {1'b0, ~thr_full_r & (tx_state_r == TX_IDLE), ~thr_full_r,
                  bi_r, fe_r, 1'b0, oe_r, dr_s};
  assign msr_s = mcr_r[4] ? {2'b00, mcr_r[0], mcr_r[1], 4'h0}
                          : {2'b00, dsr_sync_r[1], cts_sync_r[1], 4'h0};

  // Fractional 1.8432 MHz reference and divisor down-counter
  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc_r    <= 17'd0;
      ref_en_r <= 1'b0;
      cnt_r    <= RST_DIV;
      tick_r   <= 1'b0;
    end else begin
      if (acc_sum_s >= 17'(ACC_MOD)) begin
        acc_r    <= acc_sum_s - 17'(ACC_MOD);
        ref_en_r <= 1'b1;
      end else begin
        acc_r    <= acc_sum_s;
        ref_en_r <= 1'b0;
      end
      tick_r <= 1'b0;
      if (div_wr_s) begin
        cnt_r <= div_new_s;
      end else if (ref_en_r && (div_s != 16'd0)) begin
        if (cnt_r <= 16'd1) begin
          cnt_r  <= div_s;
          tick_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r - 16'd1;
        end
      end
    end
  end

  // CPU-written control registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      dll_r <= RST_DIV[7:0];
      dlm_r <= RST_DIV[15:8];
      ier_r <= 4'h0;
      lcr_r <= 8'h00;
      mcr_r <= 5'h00;
      scr_r <= 8'h00;
    end else if (wr_s) begin
      case (off_s)
        REG_RBR: if (dlab_s) dll_r <= bus.iData;
        REG_IER: if (dlab_s) dlm_r <= bus.iData; else ier_r <= bus.iData[3:0];
        REG_LCR: lcr_r <= bus.iData;
        REG_MCR: mcr_r <= bus.iData[4:0];
        REG_SCR: scr_r <= bus.iData;
        default: scr_r <= scr_r;
      endcase
    end
  end

  // Read mux: combinational so side effects on the same edge are not visible
  always_comb begin
    rdata_s = 8'h00;
    case (off_s)
      REG_RBR: if (dlab_s) rdata_s = dll_r; else rdata_s = rbr_s;
      REG_IER: if (dlab_s) rdata_s = dlm_r; else rdata_s = {4'h0, ier_r};
      REG_IIR: rdata_s = iir_s;
      REG_LCR: rdata_s = lcr_r;
      REG_MCR: rdata_s = {3'b000, mcr_r};
      REG_LSR: rdata_s = lsr_s;
      REG_MSR: rdata_s = msr_s;
      REG_SCR: rdata_s = scr_r;
      default: rdata_s = 8'h00;
    endcase
  end
  assign bus.oSel  = rd_s;
  assign bus.oData = rdata_s;

  // TX next-state; a THR write on a load tick defers the load by one tick
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
    tx_load_s  = 1'b0;
    if (tick_r) begin
      tx_cnt_s = tx_cnt_r + 4'd1;
      case (tx_state_r)
        TX_IDLE: begin
          tx_cnt_s = 4'd0;
          if (thr_full_r && !thr_wr_s) begin
            tx_load_s  = 1'b1;
            tx_shift_s = thr_r;
            tx_state_s = TX_START;
          end else begin
            tx_state_s = TX_IDLE;
          end
        end
        TX_START: begin
          if (tx_cnt_r == 4'd15) begin
            tx_bit_s   = 3'd0;
            tx_state_s = TX_DATA;
          end else begin
            tx_state_s = TX_START;
          end
        end
        TX_DATA: begin
          if (tx_cnt_r == 4'd15) begin
            tx_shift_s = {1'b1, tx_shift_r[7:1]};
            tx_bit_s   = tx_bit_r + 3'd1;
            if (tx_bit_r == 3'd7) tx_state_s = TX_STOP;
            else                  tx_state_s = TX_DATA;
          end else begin
            tx_state_s = TX_DATA;
          end
        end
        TX_STOP: begin
          if (tx_cnt_r == 4'd15) tx_state_s = TX_IDLE;
          else                   tx_state_s = TX_STOP;
        end
        default: tx_state_s = TX_IDLE;
      endcase
    end else begin
      tx_state_s = tx_state_r;
    end
  end

  always_comb begin
    case (tx_state_r)
      TX_START: tx_line_s = 1'b0;
      TX_DATA:  tx_line_s = tx_shift_r[0];
      default:  tx_line_s = 1'b1;
    endcase
  end

  // TX state, holding register and THRE-pending latch
  always_ff @(posedge iClk) begin
    if (iRst) begin
      tx_state_r  <= TX_IDLE;
      tx_cnt_r    <= 4'd0;
      tx_bit_r    <= 3'd0;
      tx_shift_r  <= 8'hFF;
      thr_r       <= 8'h00;
      thr_full_r  <= 1'b0;
      thre_pend_r <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      if (thr_wr_s) begin
        thr_r      <= bus.iData;
        thr_full_r <= 1'b1;
      end else if (tx_load_s) begin
        thr_full_r <= 1'b0;
      end
      if (thr_wr_s || iir_clr_s) thre_pend_r <= 1'b0;
      else if (tx_load_s || (ier_rise_s && !thr_full_r)) thre_pend_r <= 1'b1;
    end
  end

  assign rx_in_s = mcr_r[4] ? tx_line_s : iRx;

  uart_rx u_rx (
    .iClk       (iClk),
    .iRst       (iRst),
    .tick       (tick_r),
    .rx         (rx_in_s),
    .byte_valid (rx_valid_s),
    .data       (rx_data_s),
    .frame_err  (rx_fe_s),
    .brk        (rx_brk_s)
  );

  // Line-status error flags: new events win over a same-cycle LSR read
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oe_r <= 1'b0;
      fe_r <= 1'b0;
      bi_r <= 1'b0;
    end else begin
      if (lsr_rd_s) begin
        oe_r <= 1'b0;
        fe_r <= 1'b0;
        bi_r <= 1'b0;
      end
      if (ovr_s) oe_r <= 1'b1;
      if (rx_valid_s && rx_fe_s) fe_r <= 1'b1;
      if (rx_valid_s && rx_brk_s) bi_r <= 1'b1;
    end
  end

  // Registered pins and modem-status synchronizers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      irq_r      <= 1'b0;
      tx_out_r   <= 1'b1;
      cts_sync_r <= 2'b00;
      dsr_sync_r <= 2'b00;
    end else begin
      irq_r      <= ~iir_s[0] & mcr_r[3];
      tx_out_r   <= mcr_r[4] | tx_line_s;
      cts_sync_r <= {cts_sync_r[0], iCts};
      dsr_sync_r <= {dsr_sync_r[0], iDsr};
    end
  end

  assign oTx  = tx_out_r;
  assign oIrq = irq_r;
  assign oRts = mcr_r[1];
  assign oDtr = mcr_r[0];
endmodule

// File: tb/tb_uart_8250.sv
// Directed bench for uart_8250: register table plus TX, loopback, overrun,
// framing/break, THRE, false-start and mid-frame reset sequences.
module tb_uart_8250;
  import uart_pkg::*;

  localparam logic [15:0] BASE    = 16'h03F8;
  localparam int          BIT_CYC = 87;

  logic clk = 1'b0;
  logic rst, rx, cts, dsr, tx, rts, dtr, irq;
  int   tests = 0;
  int   fails = 0;

  uart_8250_if bus();

  uart_8250 dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus),
    .iRx  (rx),
    .oTx  (tx),
    .iCts (cts),
    .iDsr (dsr),
    .oRts (rts),
    .oDtr (dtr),
    .oIrq (irq)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [2:0] off;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    @(negedge clk);
    bus.iAddr = {4'h0, BASE[15:3], off};
    bus.iData = d;
    bus.iWr   = 1'b1;
    @(negedge clk);
    bus.iWr   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] d);
    @(negedge clk);
    bus.iAddr = {4'h0, BASE[15:3], off};
    bus.iRd   = 1'b1;
    #1 d = bus.oData;
    @(negedge clk);
    bus.iRd   = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] d;
    rd(off, d);
    check(name, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(BIT_CYC);
    end
    rx = stop;
    cyc(stop ? BIT_CYC : 70);
    rx = 1'b1;
    cyc(BIT_CYC);
  endtask

  task automatic wait_tx_low(input int limit, output logic found);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < limit) begin
      cyc(1);
      t++;
    end
    found = (tx === 1'b0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  bits;
    logic [9:0]  exp_bits;
    logic [7:0]  tx_byte;
    logic        found, tx_low;
    int          el, t;

    rst = 1'b1; rx = 1'b1; cts = 1'b1; dsr = 1'b0;
    bus.iAddr = 20'h0; bus.iData = 8'h00; bus.iWr = 1'b0; bus.iRd = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(4);

    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    bus.iAddr = {4'h0, BASE[15:3], REG_LSR};
    bus.iRd   = 1'b1;
    #1 check("sel_hit", {31'd0, bus.oSel}, 32'd1);
    bus.iAddr = 20'h002F8;
    #1 check("sel_miss", {31'd0, bus.oSel}, 32'd0);
    @(negedge clk);
    bus.iRd = 1'b0;

    vecs[0]  = '{1'b0, REG_LSR, 8'h60};
    vecs[1]  = '{1'b0, REG_IIR, 8'h01};
    vecs[2]  = '{1'b0, REG_MSR, 8'h10};
    vecs[3]  = '{1'b0, REG_LCR, 8'h00};
    vecs[4]  = '{1'b0, REG_MCR, 8'h00};
    vecs[5]  = '{1'b0, REG_IER, 8'h00};
    vecs[6]  = '{1'b1, REG_SCR, 8'h5A};
    vecs[7]  = '{1'b0, REG_SCR, 8'h5A};
    vecs[8]  = '{1'b1, REG_LCR, 8'h80};
    vecs[9]  = '{1'b0, REG_RBR, 8'h0C};
    vecs[10] = '{1'b0, REG_IER, 8'h00};
    vecs[11] = '{1'b1, REG_RBR, 8'h01};
    vecs[12] = '{1'b1, REG_IER, 8'h00};
    vecs[13] = '{1'b0, REG_RBR, 8'h01};
    vecs[14] = '{1'b1, REG_LCR, 8'h03};
    vecs[15] = '{1'b0, REG_LCR, 8'h03};
    vecs[16] = '{1'b1, REG_MCR, 8'h03};
    vecs[17] = '{1'b0, REG_MCR, 8'h03};
    vecs[18] = '{1'b1, REG_IER, 8'h0F};
    vecs[19] = '{1'b0, REG_IER, 8'h0F};
    vecs[20] = '{1'b1, REG_IER, 8'h00};
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].wr) wr(vecs[i].off, vecs[i].data);
      else rd_check($sformatf("vec%0d", i), vecs[i].off, vecs[i].data);
    end
    check("rts_on", {31'd0, rts}, 32'd1);
    check("dtr_on", {31'd0, dtr}, 32'd1);
    wr(REG_MCR, 8'h00);
    check("rts_off", {31'd0, rts}, 32'd0);

    // Transmit 8'hA5 and sample each bit near its middle
    tx_byte = 8'hA5;
    exp_bits = {1'b1, tx_byte, 1'b0};
    wr(REG_RBR, tx_byte);
    wait_tx_low(500, found);
    check("tx_start", {31'd0, found}, 32'd1);
    if (found) begin
      el = 0;
      bits = 10'd0;
      for (int k = 0; k < 10; k++) begin
        int tgt;
        tgt = 43 + (k * 868) / 10;
        cyc(tgt - el);
        el = tgt;
        bits[k] = tx;
      end
      check("tx_frame", {22'd0, bits}, {22'd0, exp_bits});
    end
    cyc(100);
    rd_check("tx_lsr_done", REG_LSR, 8'h60);
    check("tx_idle", {31'd0, tx}, 32'd1);

    // Internal loopback with RX-data interrupt
    wr(REG_MCR, 8'h18);
    wr(REG_IER, 8'h01);
    wr(REG_RBR, 8'h3C);
    t = 0;
    tx_low = 1'b0;
    while (irq !== 1'b1 && t < 3000) begin
      cyc(1);
      t++;
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    check("lb_irq", {31'd0, irq}, 32'd1);
    check("lb_tx_held", {31'd0, tx_low}, 32'd0);
    cyc(120);
    rd_check("lb_lsr", REG_LSR, 8'h61);
    rd_check("lb_iir", REG_IIR, 8'h04);
    rd_check("lb_rbr", REG_RBR, 8'h3C);
    cyc(2);
    check("lb_irq_drop", {31'd0, irq}, 32'd0);
    rd_check("lb_msr", REG_MSR, 8'h00);
    wr(REG_MCR, 8'h00);
    wr(REG_IER, 8'h00);

    // Overrun: two bytes without reading
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rd_check("ovr_lsr1", REG_LSR, 8'h63);
    rd_check("ovr_lsr2", REG_LSR, 8'h61);
    rd_check("ovr_rbr", REG_RBR, 8'h22);
    rd_check("ovr_lsr3", REG_LSR, 8'h60);

    // Break: zero data with a low stop bit
    wr(REG_IER, 8'h04);
    wr(REG_MCR, 8'h08);
    send(8'h00, 1'b0);
    rd_check("brk_iir", REG_IIR, 8'h06);
    check("brk_irq", {31'd0, irq}, 32'd1);
    rd_check("brk_lsr", REG_LSR, 8'h79);
    rd_check("brk_iir2", REG_IIR, 8'h01);
    rd_check("brk_rbr", REG_RBR, 8'h00);
    cyc(2);
    check("brk_irq_drop", {31'd0, irq}, 32'd0);

    // THRE interrupt on enable, cleared by the IIR read that reports it
    wr(REG_IER, 8'h02);
    cyc(2);
    check("thre_irq", {31'd0, irq}, 32'd1);
    rd_check("thre_iir", REG_IIR, 8'h02);
    rd_check("thre_iir2", REG_IIR, 8'h01);
    cyc(2);
    check("thre_irq_drop", {31'd0, irq}, 32'd0);

    // Short low glitch must be rejected as a false start
    wr(REG_IER, 8'h01);
    @(negedge clk);
    rx = 1'b0;
    cyc(22);
    rx = 1'b1;
    cyc(300);
    rd_check("glitch_lsr", REG_LSR, 8'h60);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // Reset in the middle of a frame
    wr(REG_RBR, 8'h55);
    wait_tx_low(500, found);
    check("rst_mid_start", {31'd0, found}, 32'd1);
    cyc(100);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    rd_check("rst_mid_lsr", REG_LSR, 8'h60);
    rd_check("rst_mid_iir", REG_IIR, 8'h01);
    cyc(200);
    check("rst_mid_quiet", {31'd0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
